uart_rx: RTL and testbench
==========================

// Module: uart_rx
//
// PURPOSE
//   8N1 UART receiver with 16x oversampling. It consumes the 16x tick from the
//   UART baud-rate generator and deserialises the asynchronous rxd line.
//   Each good frame is presented as a one-cycle valid pulse with its data byte.
//   It feeds the command/data path that loads raw image bytes into the JPEG
//   encoder.
//
// PARAMETERS
//   DATA_BITS   8   payload bits per frame, LSB first
//   OVERSAMPLE  16  rx_tick pulses per bit period; must be even and >= 4
//   SYNC_STAGES 2   flops in the rxd metastability synchroniser; >= 2
//
// PORTS
//   clk       in   1          system clock
//   nrst      in   1          reset, asynchronous, active-low
//   rx_tick   in   1          one-clk pulse, OVERSAMPLE per bit period
//   rxd       in   1          asynchronous serial input, idle high
//   rx_data   out  DATA_BITS  last correctly received byte
//   rx_valid  out  1          one-clk pulse: rx_data updated
//   rx_ferr   out  1          one-clk pulse: stop bit sampled low
//   rx_busy   out  1          high whenever state != IDLE
//
// BEHAVIOUR
//   Reset:
//   - Asynchronous reset, active-low.
//   - State goes to IDLE; all counters clear.
//   - Synchroniser flops reset to 1 (line idle).
//   - rx_data, rx_valid, rx_ferr and rx_busy all reset to 0.
//   - Reset mid-frame discards the partial byte immediately.
//   Clocking and synchronisation:
//   - The FSM advances only on clk edges where rx_tick=1.
//   - With rx_tick held at 0, the FSM holds its state.
//   - All decisions use s_rxd, the last stage of the synchroniser.
//   Counters:
//   - tick_cnt is $clog2(OVERSAMPLE) bits wide and wraps OVERSAMPLE-1 -> 0.
//   - bit_cnt is $clog2(DATA_BITS+1) bits wide.
//   States:
//   - IDLE: on a tick with s_rxd=0, clear tick_cnt and go to START.
//   - START: count ticks. At tick_cnt==OVERSAMPLE/2-1 (mid start bit):
//     - s_rxd=0: clear tick_cnt and bit_cnt, go to DATA.
//     - s_rxd=1: treat as a glitch and return to IDLE with no output.
//   - DATA: at each tick_cnt==OVERSAMPLE-1 (mid bit):
//     - shift s_rxd into the MSB of the shift register (right shift, LSB first);
//     - increment bit_cnt;
//     - after DATA_BITS samples, go to STOP.
//   - STOP: at tick_cnt==OVERSAMPLE-1:
//     - s_rxd=1: rx_data <= shift register, pulse rx_valid, go to IDLE.
//     - s_rxd=0: pulse rx_ferr, leave rx_data unchanged, go to WAIT_IDLE.
//   - WAIT_IDLE: on a tick with s_rxd=1, go to IDLE. This prevents a break
//     condition from being decoded as repeated 0x00 frames.
//   Outputs:
//   - rx_valid and rx_ferr are registered and rise in the clock cycle after
//     the sampling tick. They are high for exactly one clk and never high
//     together.
//   - There is no backpressure. rx_data is held until the next good frame, so
//     the consumer must capture it within one frame time.
//   - rx_busy is registered from the state.
//   Back-to-back frames:
//   - IDLE is entered at mid stop bit, so a start edge immediately after the
//     stop bit is detected. No idle gap is required between frames.
//   Latency:
//   - Start-bit falling edge to rx_valid is about (DATA_BITS+1.5)*OVERSAMPLE
//     ticks plus SYNC_STAGES+1 clk.
//
// TESTING (rx_tick every 28 clk, so 1 bit = 16 ticks = 448 clk)
//   1. Drive 8N1 frame 0xA5 -> one rx_valid pulse, rx_data=0xA5, rx_ferr=0,
//      rx_busy=0 afterwards.
//   2. Drive 0x00 then 0xFF back-to-back with no idle gap -> two rx_valid
//      pulses carrying 0x00 then 0xFF, no rx_ferr.
//   3. Hold rxd low for 4 ticks then high -> no rx_valid, rx_busy returns to 0;
//      a following frame 0x3C is received correctly.
//   4. Drive frame 0x55 with stop=0, then hold rxd low for 40 bits -> a single
//      rx_ferr pulse, no rx_valid, rx_data unchanged, no further pulses while
//      low. Release rxd and drive 0x81 -> rx_valid with 0x81.
//   5. Assert nrst during DATA of 0x12 -> all outputs 0 at once. After release,
//      drive 0x34 -> rx_valid with 0x34, no stale bits.
//   6. Stop rx_tick for 1000 clk mid-frame, then resume -> frame completes
//      correctly and rx_busy stays 1 throughout the pause.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver sampling rxd on a 16x oversampling tick
// Good frames pulse rx_valid with rx_data; a low stop bit pulses rx_ferr instead.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 rx_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_ferr,
    output logic                 rx_busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s_rxd;
    logic [TW-1:0]          tick_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift;
    logic                   mid_end, valid_n, ferr_n;

    assign s_rxd   = sync[SYNC_STAGES-1];
    assign mid_end = rx_tick && tick_cnt == T_END;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (rx_tick) begin
            case (state)
                IDLE:      if (!s_rxd) state_n = START;
                START:     if (tick_cnt == T_MID) state_n = s_rxd ? IDLE : DATA;
                DATA:      if (tick_cnt == T_END && bit_cnt == B_LAST) state_n = STOP;
                STOP:      if (tick_cnt == T_END) state_n = s_rxd ? IDLE : WAIT_IDLE;
                WAIT_IDLE: if (s_rxd) state_n = IDLE;
                default:   state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        valid_n = mid_end && state == STOP && s_rxd;
        ferr_n  = mid_end && state == STOP && !s_rxd;
    end

    // Datapath; tick_cnt restarts at mid start bit so later samples land mid-bit
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync     <= '1;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_busy  <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], rxd};
            rx_valid <= valid_n;
            rx_ferr  <= ferr_n;
            rx_busy  <= state_n != IDLE;
            if (valid_n) rx_data <= shift;
            if (rx_tick) begin
                tick_cnt <= (state == IDLE || (state == START && tick_cnt == T_MID) || tick_cnt == T_END)
                            ? '0 : tick_cnt + 1'b1;
                if (state == START) bit_cnt <= '0;
                if (state == DATA && tick_cnt == T_END) begin
                    shift   <= {s_rxd, shift[DATA_BITS-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed 8N1 frames against uart_rx with a 28-clk rx_tick
// Frames come from a vector table; break, glitch, reset and tick-pause are hand sequences.
module tb_uart_rx;
    localparam int BIT_CLK = 448;

    typedef struct {
        logic [7:0] data;
        int         gap;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0, nrst = 1'b0, rx_tick = 1'b0, rxd = 1'b1, tick_en = 1'b1;
    logic [7:0] rx_data, last_data = 8'h00;
    logic       rx_valid, rx_ferr, rx_busy, prev_valid = 1'b0, prev_ferr = 1'b0;
    int         checks = 0, failures = 0;
    int         valid_cnt = 0, ferr_cnt = 0, both_seen = 0, long_seen = 0;
    int         v0, f0, busy_drop;
    vec_t       vecs[4];
    logic [7:0] d;

    uart_rx dut (
        .clk(clk), .nrst(nrst), .rx_tick(rx_tick), .rxd(rxd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        repeat (27) @(negedge clk);
        rx_tick = tick_en;
        @(negedge clk);
        rx_tick = 1'b0;
    end

    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt++;
            last_data = rx_data;
        end
        if (rx_ferr) ferr_cnt++;
        if (rx_valid && rx_ferr) both_seen++;
        if ((rx_valid && prev_valid) || (rx_ferr && prev_ferr)) long_seen++;
        prev_valid = rx_valid;
        prev_ferr  = rx_ferr;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop);
    endtask

    task automatic frame_check(input string name, input logic [7:0] data, input int gap, input logic [7:0] exp);
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(data, 1'b1);
        idle_bits(gap);
        check({name, "_valid"}, valid_cnt - v0, 1);
        check({name, "_pulse_data"}, int'(last_data), int'(exp));
        check({name, "_rx_data"}, int'(rx_data), int'(exp));
        check({name, "_ferr"}, ferr_cnt - f0, 0);
        if (gap > 0) check({name, "_busy_after"}, int'(rx_busy), 0);
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, gap: 2, exp_data: 8'hA5};
        vecs[1] = '{data: 8'h00, gap: 0, exp_data: 8'h00};
        vecs[2] = '{data: 8'hFF, gap: 1, exp_data: 8'hFF};
        vecs[3] = '{data: 8'hC3, gap: 1, exp_data: 8'hC3};

        repeat (5) @(negedge clk);
        check("reset_data", int'(rx_data), 0);
        check("reset_valid", int'(rx_valid), 0);
        check("reset_ferr", int'(rx_ferr), 0);
        check("reset_busy", int'(rx_busy), 0);
        nrst = 1'b1;
        idle_bits(1);

        for (int i = 0; i < 4; i++) frame_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].gap, vecs[i].exp_data);

        // Short low glitch must be rejected at mid start bit
        v0 = valid_cnt;
        rxd = 1'b0;
        repeat (4 * 28) @(negedge clk);
        idle_bits(2);
        check("glitch_valid", valid_cnt - v0, 0);
        check("glitch_busy", int'(rx_busy), 0);
        frame_check("after_glitch", 8'h3C, 1, 8'h3C);

        // Framing error followed by a 40-bit break
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        repeat (40 * BIT_CLK) @(negedge clk);
        idle_bits(2);
        check("break_ferr", ferr_cnt - f0, 1);
        check("break_valid", valid_cnt - v0, 0);
        check("break_data_held", int'(rx_data), 8'h3C);
        frame_check("after_break", 8'h81, 1, 8'h81);

        // Asynchronous reset in the middle of the data bits of 0x12
        d = 8'h12;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        check("busy_mid_frame", int'(rx_busy), 1);
        #2 nrst = 1'b0;
        #1;
        check("midreset_data", int'(rx_data), 0);
        check("midreset_valid", int'(rx_valid), 0);
        check("midreset_ferr", int'(rx_ferr), 0);
        check("midreset_busy", int'(rx_busy), 0);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        nrst = 1'b1;
        idle_bits(1);
        frame_check("after_reset", 8'h34, 1, 8'h34);

        // rx_tick paused for 1000 clk in the middle of data bit 4 of 0x96
        d = 8'h96;
        v0 = valid_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rxd = d[4];
        repeat (BIT_CLK / 2) @(negedge clk);
        tick_en = 1'b0;
        busy_drop = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!rx_busy) busy_drop++;
        end
        tick_en = 1'b1;
        repeat (BIT_CLK / 2) @(negedge clk);
        for (int i = 5; i < 8; i++) send_bit(d[i]);
        send_bit(1'b1);
        idle_bits(1);
        check("pause_busy_drop", busy_drop, 0);
        check("pause_valid", valid_cnt - v0, 1);
        check("pause_data", int'(rx_data), 8'h96);

        check("valid_ferr_together", both_seen, 0);
        check("pulse_longer_than_one", long_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
